ps2_cmd_decoder: RTL and testbench
==================================

PS2_CMD_DECODER -- requirements
Module: ps2_cmd_decoder

Interface
REQ-001 Parameter CODE_W, default 4, width of cmd_code; legal range 4..8.
REQ-002 Parameter FIFO_DEPTH, default 4, command FIFO entries; power of two, 2..16.
REQ-003 Parameter REPEAT_FILTER, default 1, 1 = suppress typematic repeat makes.
REQ-004 Parameter EMIT_BREAK, default 0, 1 = key releases also produce commands.
REQ-005 Parameter TIMEOUT_CYC, default 100000, clk cycles a prefix state waits before abandoning.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 reset  input  1  reset, synchronous, active-high.
REQ-008 scan_valid  input  1  one-cycle strobe, scan_code holds a new PS/2 set-2 byte.
REQ-009 scan_code  input  8  received scancode byte.
REQ-010 cmd_ready  input  1  consumer accepts the head command when high with cmd_valid.
REQ-011 cmd_valid  output  1  FIFO non-empty; head command present.
REQ-012 cmd_code  output  CODE_W  head command code, zero-extended above bit 3.
REQ-013 cmd_break  output  1  head command is a release event.
REQ-014 overflow  output  1  sticky flag, a command was dropped because the FIFO was full.

Function
REQ-015 Key map, non-extended: 16->0, 1E->1, 26->2, 25->3, 2D->4 (R), 34->5 (G), 32->6 (B), 79->B (+), 7B->C (-), 2B->D (f).
REQ-016 Key map, E0-extended: 75->7 (up), 72->8 (down), 6B->9 (left), 74->A (right).
REQ-017 Unmapped bytes, and mapped bytes arriving in the wrong extended/non-extended context, produce no command; code E is never pushed.
REQ-018 The FSM has states IDLE, EXT, BRK and EXT_BRK, and advances only on cycles with scan_valid high.
REQ-019 IDLE transitions: E0->EXT; F0->BRK; any other byte->decode as make, stay IDLE.
REQ-020 EXT transitions: F0->EXT_BRK; E0->stay EXT; any other byte->decode extended make, go IDLE.
REQ-021 BRK transitions: F0->stay BRK; any other byte->decode break, go IDLE.
REQ-022 EXT_BRK transitions: any byte other than E0/F0->decode extended break, go IDLE; E0/F0->stay EXT_BRK.
REQ-023 E1 bytes and their followers are treated as unmapped bytes with no special sequencing.
REQ-024 Prefix timeout: a counter reloads on every accepted byte; if no byte arrives within TIMEOUT_CYC cycles in EXT/BRK/EXT_BRK, the FSM returns to IDLE and no command is produced.
REQ-025 Held mask: one bit per key 0..D; a make sets the key's bit and a break clears it.
REQ-026 With REPEAT_FILTER=1, a make for a key whose held bit is already set is suppressed; with REPEAT_FILTER=0 every make pushes.
REQ-027 A make pushes {code, break=0}; a break pushes {code, break=1} only when EMIT_BREAK=1, regardless of held state.
REQ-028 Latency: a command decoded from a byte sampled at edge N is written at edge N; cmd_valid/cmd_code/cmd_break reflect it after edge N when the FIFO was empty (first-word fall-through).
REQ-029 Pop occurs on any edge with cmd_valid and cmd_ready both high; outputs hold steady while cmd_ready is low.
REQ-030 Push and pop in the same cycle are both performed, including when full; occupancy is unchanged and overflow is not set.
REQ-031 A push to a full FIFO without a simultaneous pop discards the new command, sets overflow, and leaves FIFO contents intact.
REQ-032 Read/write pointers wrap modulo FIFO_DEPTH; occupancy is held in a clog2(FIFO_DEPTH)+1-bit count.
REQ-033 cmd_ready while empty has no effect.

Reset
REQ-034 On a reset edge: FSM goes to IDLE, timeout counter cleared, held mask cleared, FIFO emptied, cmd_valid=0, cmd_code=0, cmd_break=0, overflow=0.
REQ-035 Reset overrides any concurrent scan_valid or pop; a partially received prefix sequence is discarded.
REQ-036 overflow clears only on reset.

Verification
REQ-037 Bytes 2D, cmd_ready=1 -> cmd_valid high one cycle after the 2D edge with cmd_code=4, cmd_break=0.
REQ-038 Bytes E0,75 then E0,F0,75 with EMIT_BREAK=1 -> two commands: {7, break 0} then {7, break 1}; a bare 75 -> no command.
REQ-039 REPEAT_FILTER=1, bytes 16,16,16,F0,16,16 -> exactly two make commands with code 0.
REQ-040 cmd_ready=0, FIFO_DEPTH=4, five mapped makes of distinct keys -> first four retained in order, overflow=1; then a push and pop in the same cycle -> count stays 4.
REQ-041 E0 then silence for TIMEOUT_CYC cycles then 6B -> FSM is back in IDLE, 6B is non-extended, so no command is produced.
REQ-042 Reset asserted between F0 and 34 -> the following 34 is decoded as make code 5; all outputs are 0 during reset.

Source files
------------

// File: rtl/ps2_cmd_decoder.sv
// PS/2 set-2 scancode decoder: maps a small key set to command codes and queues them in a FIFO.
// Latency: command written on the edge that samples its final byte; visible right after (fall-through FIFO).
// Backpressure: cmd_valid/cmd_ready handshake; a push into a full FIFO with no pop is dropped and sets sticky overflow.
module ps2_cmd_decoder #(
    parameter int CODE_W        = 4,
    parameter int FIFO_DEPTH    = 4,
    parameter int REPEAT_FILTER = 1,
    parameter int EMIT_BREAK    = 0,
    parameter int TIMEOUT_CYC   = 100000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              scan_valid,
    input  logic [7:0]        scan_code,
    input  logic              cmd_ready,
    output logic              cmd_valid,
    output logic [CODE_W-1:0] cmd_code,
    output logic              cmd_break,
    output logic              overflow
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK} state_t;

    typedef struct packed {
        logic [3:0] code;
        logic       brk;
    } cmd_t;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [13:0]        held_q, held_d;
    cmd_t               mem_q [FIFO_DEPTH];
    cmd_t               mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;

    logic               ext_ctx, brk_ctx, term;
    logic               key_hit;
    logic [3:0]         key_code;
    logic               push_vld, pop, full, do_push;

    // FSM state register and prefix timeout counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Next state: advance on accepted bytes, fall back to IDLE when a prefix goes stale
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        if (scan_valid) begin
            timer_d = '0;
            case (state_q)
                ST_IDLE:    state_d = (scan_code == 8'hE0) ? ST_EXT :
                                      (scan_code == 8'hF0) ? ST_BRK : ST_IDLE;
                ST_EXT:     state_d = (scan_code == 8'hF0) ? ST_EXT_BRK :
                                      (scan_code == 8'hE0) ? ST_EXT : ST_IDLE;
                ST_BRK:     state_d = (scan_code == 8'hF0) ? ST_BRK : ST_IDLE;
                ST_EXT_BRK: state_d = (scan_code == 8'hE0 || scan_code == 8'hF0) ? ST_EXT_BRK : ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE) begin
            if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
                state_d = ST_IDLE;
                timer_d = '0;
            end else begin
                timer_d = timer_q + TMR_W'(1);
            end
        end
    end

    // FSM outputs: decode context and whether this byte completes a make/break sequence
    always_comb begin
        ext_ctx = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
        brk_ctx = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
        term    = 1'b0;
        case (state_q)
            ST_BRK:  term = scan_valid && (scan_code != 8'hF0);
            default: term = scan_valid && (scan_code != 8'hE0) && (scan_code != 8'hF0);
        endcase
    end

    // Key map; extended and plain keys only match in their own context
    always_comb begin
        key_hit  = 1'b1;
        key_code = 4'h0;
        if (ext_ctx) begin
            case (scan_code)
                8'h75:   key_code = 4'h7;
                8'h72:   key_code = 4'h8;
                8'h6B:   key_code = 4'h9;
                8'h74:   key_code = 4'hA;
                default: key_hit  = 1'b0;
            endcase
        end else begin
            case (scan_code)
                8'h16:   key_code = 4'h0;
                8'h1E:   key_code = 4'h1;
                8'h26:   key_code = 4'h2;
                8'h25:   key_code = 4'h3;
                8'h2D:   key_code = 4'h4;
                8'h34:   key_code = 4'h5;
                8'h32:   key_code = 4'h6;
                8'h79:   key_code = 4'hB;
                8'h7B:   key_code = 4'hC;
                8'h2B:   key_code = 4'hD;
                default: key_hit  = 1'b0;
            endcase
        end
    end

    // Held-key tracking, repeat suppression and FIFO bookkeeping
    always_comb begin
        held_d   = held_q;
        push_vld = 1'b0;
        if (term && key_hit) begin
            if (brk_ctx) begin
                held_d[key_code] = 1'b0;
                push_vld         = (EMIT_BREAK != 0);
            end else begin
                held_d[key_code] = 1'b1;
                push_vld         = !((REPEAT_FILTER != 0) && held_q[key_code]);
            end
        end

        pop     = (count_q != '0) && cmd_ready;
        full    = (count_q == CNT_W'(FIFO_DEPTH));
        do_push = push_vld && (!full || pop);

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = '{code: key_code, brk: brk_ctx};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(pop);
        ovf_d   = ovf_q || (push_vld && full && !pop);
    end

    // Held mask, FIFO storage, pointers and overflow flag
    always_ff @(posedge clk) begin
        if (reset) begin
            held_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            held_q   <= held_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            mem_q    <= mem_d;
        end
    end

    // Head of FIFO presented directly; fields forced to zero when empty
    always_comb begin
        cmd_valid = (count_q != '0);
        cmd_code  = cmd_valid ? CODE_W'(mem_q[rd_ptr_q].code) : '0;
        cmd_break = cmd_valid && mem_q[rd_ptr_q].brk;
        overflow  = ovf_q;
    end

endmodule

// File: tb/tb_ps2_cmd_decoder.sv
// Bench for ps2_cmd_decoder: two configurations driven by the same byte stream,
// checked every cycle against a queue-based reference model, plus directed scenarios.
module tb_ps2_cmd_decoder;

    localparam int T = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic       scan_valid;
    logic [7:0] scan_code;
    logic       cmd_ready;

    logic       cmd_valid_a, cmd_break_a, overflow_a;
    logic [5:0] cmd_code_a;
    logic       cmd_valid_b, cmd_break_b, overflow_b;
    logic [3:0] cmd_code_b;

    always #5 clk = ~clk;

    ps2_cmd_decoder #(.CODE_W(6), .FIFO_DEPTH(4), .REPEAT_FILTER(1), .EMIT_BREAK(1), .TIMEOUT_CYC(T)) dut_a (
        .clk(clk), .reset(reset), .scan_valid(scan_valid), .scan_code(scan_code), .cmd_ready(cmd_ready),
        .cmd_valid(cmd_valid_a), .cmd_code(cmd_code_a), .cmd_break(cmd_break_a), .overflow(overflow_a));

    ps2_cmd_decoder #(.CODE_W(4), .FIFO_DEPTH(8), .REPEAT_FILTER(0), .EMIT_BREAK(0), .TIMEOUT_CYC(T)) dut_b (
        .clk(clk), .reset(reset), .scan_valid(scan_valid), .scan_code(scan_code), .cmd_ready(cmd_ready),
        .cmd_valid(cmd_valid_b), .cmd_code(cmd_code_b), .cmd_break(cmd_break_b), .overflow(overflow_b));

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    bit rdy = 1'b0;
    bit rst = 1'b0;

    // reference model: shared prefix context, per-instance queues (entry = code*2 + break)
    bit        m_ext, m_brk;
    int        m_last;
    bit [15:0] m_held;
    int        q0[$];
    int        q1[$];
    bit        m_ovf0, m_ovf1;

    int seen_mk_a, seen_mk_b;

    logic [7:0] pool [0:18] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2D, 8'h34, 8'h32, 8'h79, 8'h7B,
                                8'h2B, 8'h75, 8'h72, 8'h6B, 8'h74, 8'hE0, 8'hF0, 8'hE0, 8'hF0, 8'hE1};

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic int keymap(input logic [7:0] b, input bit ext);
        if (ext) begin
            case (b)
                8'h75: return 7;
                8'h72: return 8;
                8'h6B: return 9;
                8'h74: return 10;
                default: return -1;
            endcase
        end
        case (b)
            8'h16: return 0;
            8'h1E: return 1;
            8'h26: return 2;
            8'h25: return 3;
            8'h2D: return 4;
            8'h34: return 5;
            8'h32: return 6;
            8'h79: return 11;
            8'h7B: return 12;
            8'h2B: return 13;
            default: return -1;
        endcase
    endfunction

    task automatic model_step(input bit v, input logic [7:0] b, input bit r, input bit rs);
        int  key;
        int  ent;
        bit  is_brk;
        bit  got_key;
        bit  p0, p1;
        bit  pop0, pop1;
        int  sz0, sz1;
        if (rs) begin
            m_ext = 0; m_brk = 0; m_held = '0; m_ovf0 = 0; m_ovf1 = 0;
            q0.delete(); q1.delete();
            return;
        end
        p0 = 0; p1 = 0; ent = 0; got_key = 0; is_brk = 0; key = -1;
        if (v) begin
            if ((m_ext || m_brk) && (cyc - m_last > T)) begin
                m_ext = 0; m_brk = 0;
            end
            m_last = cyc;
            if (!m_ext && !m_brk) begin
                if (b == 8'hE0) m_ext = 1;
                else if (b == 8'hF0) m_brk = 1;
                else begin key = keymap(b, 0); got_key = 1; is_brk = 0; end
            end else if (m_ext && !m_brk) begin
                if (b == 8'hF0) m_brk = 1;
                else if (b != 8'hE0) begin key = keymap(b, 1); got_key = 1; is_brk = 0; m_ext = 0; end
            end else if (!m_ext && m_brk) begin
                if (b != 8'hF0) begin key = keymap(b, 0); got_key = 1; is_brk = 1; m_brk = 0; end
            end else begin
                if (b != 8'hE0 && b != 8'hF0) begin
                    key = keymap(b, 1); got_key = 1; is_brk = 1; m_ext = 0; m_brk = 0;
                end
            end
            if (got_key && key >= 0) begin
                ent = key * 2 + int'(is_brk);
                if (is_brk) begin
                    m_held[key] = 0;
                    p0 = 1;
                    p1 = 0;
                end else begin
                    p0 = !m_held[key];
                    p1 = 1;
                    m_held[key] = 1;
                end
            end
        end
        sz0 = q0.size(); sz1 = q1.size();
        pop0 = (sz0 > 0) && r;
        pop1 = (sz1 > 0) && r;
        if (pop0) void'(q0.pop_front());
        if (pop1) void'(q1.pop_front());
        if (p0) begin
            if (sz0 < 4 || pop0) q0.push_back(ent);
            else m_ovf0 = 1;
        end
        if (p1) begin
            if (sz1 < 8 || pop1) q1.push_back(ent);
            else m_ovf1 = 1;
        end
    endtask

    task automatic compare_all();
        int e0, e1;
        e0 = (q0.size() > 0) ? q0[0] : 0;
        e1 = (q1.size() > 0) ? q1[0] : 0;
        check("a_valid", int'(cmd_valid_a), int'(q0.size() > 0));
        check("a_code",  int'(cmd_code_a),  e0 / 2);
        check("a_break", int'(cmd_break_a), e0 % 2);
        check("a_ovf",   int'(overflow_a),  int'(m_ovf0));
        check("b_valid", int'(cmd_valid_b), int'(q1.size() > 0));
        check("b_code",  int'(cmd_code_b),  e1 / 2);
        check("b_break", int'(cmd_break_b), e1 % 2);
        check("b_ovf",   int'(overflow_b),  int'(m_ovf1));
    endtask

    // one clock: drive at negedge, model on posedge, compare on next negedge
    task automatic tick(input bit v, input logic [7:0] b);
        scan_valid = v;
        scan_code  = b;
        cmd_ready  = rdy;
        reset      = rst;
        @(posedge clk);
        cyc++;
        model_step(v, b, rdy, rst);
        @(negedge clk);
        compare_all();
        if (cmd_valid_a && !cmd_break_a) seen_mk_a++;
        if (cmd_valid_b && !cmd_break_b) seen_mk_b++;
    endtask

    task automatic do_reset();
        rst = 1;
        tick(0, 8'h00);
        tick(1, 8'h2D);
        rst = 0;
    endtask

    initial begin
        bit         v;
        logic [7:0] b;
        int         sil;
        reset = 1; scan_valid = 0; scan_code = 0; cmd_ready = 0;
        m_ext = 0; m_brk = 0; m_held = '0; m_ovf0 = 0; m_ovf1 = 0; m_last = 0;
        @(negedge clk);

        // reset state
        do_reset();
        check("rst_valid", int'(cmd_valid_a), 0);
        check("rst_ovf", int'(overflow_a), 0);

        // single make, visible one cycle after its byte
        rdy = 1;
        tick(1, 8'h2D);
        check("r037_valid", int'(cmd_valid_a), 1);
        check("r037_code", int'(cmd_code_a), 4);
        check("r037_break", int'(cmd_break_a), 0);
        tick(0, 8'h00);

        // extended make, extended break, bare 75
        do_reset(); rdy = 0;
        tick(1, 8'hE0); tick(1, 8'h75);
        tick(1, 8'hE0); tick(1, 8'hF0); tick(1, 8'h75);
        tick(1, 8'h75);
        check("r038_head_code", int'(cmd_code_a), 7);
        check("r038_head_brk", int'(cmd_break_a), 0);
        rdy = 1; tick(0, 8'h00);
        check("r038_second_code", int'(cmd_code_a), 7);
        check("r038_second_brk", int'(cmd_break_a), 1);
        tick(0, 8'h00);
        check("r038_empty", int'(cmd_valid_a), 0);

        // typematic repeat filtering
        do_reset(); rdy = 1;
        seen_mk_a = 0; seen_mk_b = 0;
        tick(1, 8'h16); tick(1, 8'h16); tick(1, 8'h16);
        tick(1, 8'hF0); tick(1, 8'h16); tick(1, 8'h16);
        tick(0, 8'h00); tick(0, 8'h00);
        check("r039_makes_a", seen_mk_a, 2);
        check("r039_makes_b", seen_mk_b, 4);

        // overflow then simultaneous push/pop while full
        do_reset(); rdy = 0;
        tick(1, 8'h16); tick(1, 8'h1E); tick(1, 8'h26); tick(1, 8'h25); tick(1, 8'h2D);
        check("r040_ovf_a", int'(overflow_a), 1);
        check("r040_ovf_b", int'(overflow_b), 0);
        rdy = 1; tick(1, 8'h34);
        check("r040_head_after_pp", int'(cmd_code_a), 1);
        repeat (6) tick(0, 8'h00);
        check("r040_ovf_sticky", int'(overflow_a), 1);

        // prefix timeout: one cycle short keeps the prefix, full window drops it
        do_reset(); rdy = 1;
        tick(1, 8'hE0); repeat (T - 1) tick(0, 8'h00); tick(1, 8'h6B);
        check("r041_inwin_valid", int'(cmd_valid_a), 1);
        check("r041_inwin_code", int'(cmd_code_a), 9);
        tick(0, 8'h00);
        tick(1, 8'hE0); repeat (T) tick(0, 8'h00); tick(1, 8'h6B);
        check("r041_timeout_valid", int'(cmd_valid_a), 0);

        // reset discards a pending break prefix; outputs zero during reset
        rdy = 0;
        tick(1, 8'h16);
        tick(1, 8'hF0);
        rst = 1; tick(1, 8'hF0);
        check("r042_rst_valid", int'(cmd_valid_a), 0);
        check("r042_rst_code", int'(cmd_code_a), 0);
        rst = 0;
        tick(1, 8'h34);
        check("r042_code", int'(cmd_code_a), 5);
        check("r042_break", int'(cmd_break_a), 0);

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(0, 499) == 0);
            if (((k / 64) % 3) == 0) rdy = ($urandom_range(0, 9) == 0);
            else rdy = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 79) == 0) begin
                sil = $urandom_range(T - 2, T + 2);
                for (int s = 0; s < sil; s++) tick(0, 8'h00);
            end
            v = ($urandom_range(0, 9) < 4);
            if ($urandom_range(0, 9) == 0) b = 8'($urandom_range(0, 255));
            else b = pool[$urandom_range(0, 18)];
            tick(v, b);
        end
        rst = 0; rdy = 1;
        repeat (12) tick(0, 8'h00);
        check("drain_a", int'(cmd_valid_a), 0);
        check("drain_b", int'(cmd_valid_b), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
